// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers producer bursts and issues one tx_e_o pulse per
// stored byte, only while uart_tx reports idle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_e_i,
  input  logic [7:0]               wr_d_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  input  logic                     tx_busy_i,
  output logic                     tx_e_o,
  output logic [7:0]               tx_d_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e            state_q, state_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        tx_d_q, tx_d_d;
  logic [7:0]        mem_q [DEPTH];

  logic              pop;
  logic              push;

  // Sequencer: the IDLE->ISSUE transition is the pop, so an empty FIFO is never read.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && !tx_busy_i) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy_i) begin
          state_d = StWaitDone;
        end else if (tmo_q == TmoW'(BUSY_TIMEOUT - 1)) begin
          // uart_tx never acknowledged; treat the byte as sent rather than stall.
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A write into a full FIFO still lands when the same edge frees a slot.
  always_comb begin
    push       = wr_e_i && ((count_q != CntW'(DEPTH)) || pop);
    overflow_d = overflow_q | (wr_e_i & ~push);
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    tx_d_d     = pop ? mem_q[rd_ptr_q] : tx_d_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_d_q     <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_d_q     <= tx_d_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_d_i;
    end
  end

  assign tx_e_o     = (state_q == StIssue);
  assign tx_d_o     = tx_d_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue model of the FIFO plus a simple uart_tx
// busy model, with per-scenario checks.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned BT    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_e_i = 1'b0;
  logic [7:0] wr_d_i = '0;
  logic       full_o;
  logic       empty_o;
  logic [4:0] count_o;
  logic       overflow_o;
  logic       tx_busy_i = 1'b0;
  logic       tx_e_o;
  logic [7:0] tx_d_o;

  uart_tx_fifo #(
    .DEPTH       (DEPTH),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_e_i    (wr_e_i),
    .wr_d_i    (wr_d_i),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .count_o   (count_o),
    .overflow_o(overflow_o),
    .tx_busy_i (tx_busy_i),
    .tx_e_o    (tx_e_o),
    .tx_d_o    (tx_d_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model and observation records.
  logic [7:0] model_q[$];
  logic [7:0] acc_q[$];
  logic [7:0] pulse_d[$];
  int         pulse_c[$];
  logic       model_ovf = 1'b0;
  int         cyc = 0;
  int         busy_err = 0;
  int         consec_err = 0;
  int         count_err = 0;
  bit         prev_e = 1'b0;

  // uart_tx stand-in: 0 = never busy, 1 = busy for busy_len cycles starting one cycle
  // after e_i, 2 = permanently busy.
  int busy_mode = 1;
  int busy_len = 20;
  int busy_left = 0;
  bit busy_pend = 1'b0;

  task automatic step();
    int sz;
    bit popped;
    sz = model_q.size();
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      model_q.delete();
      model_ovf = 1'b0;
      busy_left = 0;
      busy_pend = 1'b0;
    end else begin
      popped = tx_e_o;
      if (popped) begin
        if (tx_busy_i) busy_err++;
        if (prev_e) consec_err++;
        pulse_d.push_back(tx_d_o);
        pulse_c.push_back(cyc);
        if (sz > 0) void'(model_q.pop_front());
      end
      if (wr_e_i) begin
        if (sz < int'(DEPTH) || popped) begin
          model_q.push_back(wr_d_i);
          acc_q.push_back(wr_d_i);
        end else begin
          model_ovf = 1'b1;
        end
      end
    end
    if (int'(count_o) != model_q.size() || empty_o !== (model_q.size() == 0) ||
        full_o !== (model_q.size() == int'(DEPTH)) || overflow_o !== model_ovf)
      count_err++;
    prev_e = tx_e_o;
    case (busy_mode)
      0: tx_busy_i = 1'b0;
      2: tx_busy_i = 1'b1;
      default: begin
        if (busy_pend) begin
          tx_busy_i = 1'b1;
          busy_left = busy_len - 1;
          busy_pend = 1'b0;
        end else if (busy_left > 0) begin
          busy_left--;
        end else begin
          tx_busy_i = 1'b0;
        end
        if (tx_e_o && !reset) busy_pend = 1'b1;
      end
    endcase
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (pulse_d.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic clear_stats();
    pulse_d.delete();
    pulse_c.delete();
    acc_q.delete();
    busy_err = 0;
    consec_err = 0;
    count_err = 0;
  endtask

  task automatic do_reset();
    wr_e_i = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    busy_mode = 1;
    do_reset();
    vectors++;
    if (tx_e_o !== 1'b0 || tx_d_o !== 8'h00 || count_o !== 5'd0 || empty_o !== 1'b1 ||
        full_o !== 1'b0 || overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: e=%b d=%02h cnt=%0d empty=%b full=%b ovf=%b, expected 0 00 0 1 0 0",
               tx_e_o, tx_d_o, count_o, empty_o, full_o, overflow_o);
    end
  endtask

  task automatic test_single();
    clear_stats();
    busy_mode = 1;
    busy_len = 20;
    wr_e_i = 1'b1;
    wr_d_i = 8'hA5;
    step();
    wr_e_i = 1'b0;
    vectors++;
    if (count_o !== 5'd1 || tx_e_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_write: cnt=%0d e=%b, expected cnt=1 e=0", count_o, tx_e_o);
    end
    step();
    vectors++;
    if (tx_e_o !== 1'b1 || tx_d_o !== 8'hA5 || count_o !== 5'd0) begin
      miscompares++;
      $display("FAIL single_issue: e=%b d=%02h cnt=%0d, expected e=1 d=a5 cnt=0",
               tx_e_o, tx_d_o, count_o);
    end
    repeat (30) step();
    vectors++;
    if (pulse_d.size() != 1 || busy_err != 0 || count_err != 0) begin
      miscompares++;
      $display("FAIL single_pulses: pulses=%0d busy_err=%0d count_err=%0d, expected 1 0 0",
               pulse_d.size(), busy_err, count_err);
    end
  endtask

  task automatic test_burst();
    clear_stats();
    busy_len = int'($urandom_range(1, 6));
    for (int i = 0; i < 5; i++) begin
      wr_e_i = 1'b1;
      wr_d_i = 8'(i + 1);
      step();
    end
    wr_e_i = 1'b0;
    run_until(5, 300);
    vectors++;
    if (pulse_d.size() != 5) begin
      miscompares++;
      $display("FAIL burst_count: got %0d pulses, expected 5", pulse_d.size());
    end
    for (int i = 0; i < 5 && i < pulse_d.size(); i++) begin
      vectors++;
      if (pulse_d[i] !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL burst_data[%0d]: got %02h, expected %02h", i, pulse_d[i], 8'(i + 1));
      end
    end
    vectors++;
    if (busy_err != 0 || consec_err != 0 || count_err != 0) begin
      miscompares++;
      $display("FAIL burst_protocol: busy_err=%0d consec_err=%0d count_err=%0d, expected 0 0 0",
               busy_err, consec_err, count_err);
    end
    repeat (30) step();
  endtask

  task automatic test_full_overflow();
    clear_stats();
    busy_mode = 2;
    tx_busy_i = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      wr_e_i = 1'b1;
      wr_d_i = 8'(8'h10 + i);
      step();
      if (i == 15) begin
        vectors++;
        if (full_o !== 1'b1 || count_o !== 5'd16 || overflow_o !== 1'b0) begin
          miscompares++;
          $display("FAIL full_after_16: full=%b cnt=%0d ovf=%b, expected 1 16 0",
                   full_o, count_o, overflow_o);
        end
      end
    end
    wr_e_i = 1'b0;
    vectors++;
    if (overflow_o !== 1'b1 || count_o !== 5'd16) begin
      miscompares++;
      $display("FAIL overflow_17th: ovf=%b cnt=%0d, expected 1 16", overflow_o, count_o);
    end
    busy_mode = 1;
    busy_len = 2;
    tx_busy_i = 1'b0;
    run_until(16, 400);
    repeat (20) step();
    vectors++;
    if (pulse_d.size() != 16) begin
      miscompares++;
      $display("FAIL full_drain_count: got %0d pulses, expected 16", pulse_d.size());
    end
    for (int i = 0; i < 16 && i < pulse_d.size(); i++) begin
      vectors++;
      if (pulse_d[i] !== 8'(8'h10 + i)) begin
        miscompares++;
        $display("FAIL full_drain_data[%0d]: got %02h, expected %02h", i, pulse_d[i],
                 8'(8'h10 + i));
      end
    end
    vectors++;
    if (overflow_o !== 1'b1 || empty_o !== 1'b1 || count_err != 0 || busy_err != 0) begin
      miscompares++;
      $display("FAIL overflow_sticky: ovf=%b empty=%b count_err=%0d busy_err=%0d, expected 1 1 0 0",
               overflow_o, empty_o, count_err, busy_err);
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    do_reset();
    clear_stats();
    busy_mode = 2;
    tx_busy_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wr_e_i = 1'b1;
      wr_d_i = b;
      step();
    end
    exp_q.push_back(8'hEE);
    busy_mode = 0;
    tx_busy_i = 1'b0;
    wr_d_i = 8'hEE;
    step();
    wr_e_i = 1'b0;
    vectors++;
    if (tx_e_o !== 1'b1 || count_o !== 5'd16 || full_o !== 1'b1 || overflow_o !== 1'b0 ||
        tx_d_o !== exp_q[0]) begin
      miscompares++;
      $display("FAIL simul_push_pop: e=%b cnt=%0d full=%b ovf=%b d=%02h, expected 1 16 1 0 %02h",
               tx_e_o, count_o, full_o, overflow_o, tx_d_o, exp_q[0]);
    end
    busy_mode = 1;
    busy_len = 1;
    run_until(17, 600);
    vectors++;
    if (pulse_d.size() != 17) begin
      miscompares++;
      $display("FAIL simul_drain_count: got %0d pulses, expected 17", pulse_d.size());
    end
    for (int i = 0; i < 17 && i < pulse_d.size(); i++) begin
      vectors++;
      if (pulse_d[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL simul_drain_data[%0d]: got %02h, expected %02h", i, pulse_d[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    clear_stats();
    busy_mode = 1;
    busy_len = int'($urandom_range(1, 2));
    for (int i = 0; i < 40; i++) begin
      wr_e_i = 1'b1;
      wr_d_i = 8'($urandom);
      step();
      wr_e_i = 1'b0;
      repeat ($urandom_range(2, 6)) step();
    end
    n = acc_q.size();
    run_until(n, 600);
    repeat (10) step();
    vectors++;
    if (n != 40 || pulse_d.size() != 40 || overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_count: accepted=%0d pulses=%0d ovf=%b, expected 40 40 0",
               n, pulse_d.size(), overflow_o);
    end
    for (int i = 0; i < n && i < pulse_d.size(); i++) begin
      vectors++;
      if (pulse_d[i] !== acc_q[i]) begin
        miscompares++;
        $display("FAIL wrap_data[%0d]: got %02h, expected %02h", i, pulse_d[i], acc_q[i]);
      end
    end
    vectors++;
    if (busy_err != 0 || consec_err != 0 || count_err != 0) begin
      miscompares++;
      $display("FAIL wrap_protocol: busy_err=%0d consec_err=%0d count_err=%0d, expected 0 0 0",
               busy_err, consec_err, count_err);
    end
  endtask

  task automatic test_timeout();
    int gap;
    do_reset();
    clear_stats();
    busy_mode = 0;
    tx_busy_i = 1'b0;
    wr_e_i = 1'b1;
    wr_d_i = 8'h3C;
    step();
    wr_d_i = 8'h3D;
    step();
    wr_e_i = 1'b0;
    run_until(2, 60);
    repeat (12) step();
    vectors++;
    if (pulse_d.size() != 2) begin
      miscompares++;
      $display("FAIL timeout_count: got %0d pulses, expected 2", pulse_d.size());
    end else begin
      gap = pulse_c[1] - pulse_c[0];
      vectors++;
      if (pulse_d[0] !== 8'h3C || pulse_d[1] !== 8'h3D) begin
        miscompares++;
        $display("FAIL timeout_data: got %02h %02h, expected 3c 3d", pulse_d[0], pulse_d[1]);
      end
      vectors++;
      if (gap < int'(BT) + 1 || gap > int'(BT) + 2) begin
        miscompares++;
        $display("FAIL timeout_spacing: got %0d cycles, expected %0d..%0d", gap, BT + 1, BT + 2);
      end
    end
    vectors++;
    if (empty_o !== 1'b1 || count_err != 0) begin
      miscompares++;
      $display("FAIL timeout_end: empty=%b count_err=%0d, expected 1 0", empty_o, count_err);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    clear_stats();
    busy_mode = 1;
    busy_len = 20;
    for (int i = 0; i < 4; i++) begin
      wr_e_i = 1'b1;
      wr_d_i = 8'(8'h50 + i);
      step();
    end
    wr_e_i = 1'b0;
    while (!tx_busy_i && k < 50) begin
      step();
      k++;
    end
    repeat (3) step();
    vectors++;
    if (count_o !== 5'd3 || tx_busy_i !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup: cnt=%0d busy=%b, expected 3 1", count_o, tx_busy_i);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (count_o !== 5'd0 || empty_o !== 1'b1 || tx_e_o !== 1'b0 || overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: cnt=%0d empty=%b e=%b ovf=%b, expected 0 1 0 0",
               count_o, empty_o, tx_e_o, overflow_o);
    end
    busy_mode = 0;
    tx_busy_i = 1'b0;
    pulse_d.delete();
    repeat (25) step();
    vectors++;
    if (pulse_d.size() != 0) begin
      miscompares++;
      $display("FAIL mid_no_issue: got %0d pulses, expected 0", pulse_d.size());
    end
    wr_e_i = 1'b1;
    wr_d_i = 8'h77;
    step();
    wr_e_i = 1'b0;
    run_until(1, 20);
    vectors++;
    if (pulse_d.size() != 1 || (pulse_d.size() == 1 && pulse_d[0] !== 8'h77)) begin
      miscompares++;
      $display("FAIL mid_resume: got %0d pulses, expected one carrying 77", pulse_d.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_full_simul();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus transmit sequencer between a byte producer (uart_rx done_o/d_o, or a CPU-side writer) and uart_tx (e_i/d_i/busy_o).
- Absorbs bursts: uart_rx can deliver back-to-back bytes while uart_tx is still shifting.
- Issues exactly one single-cycle e_i pulse per stored byte, and only when uart_tx is idle.

Parameters:
DEPTH, 16, FIFO capacity in bytes; must be a power of two, at least 2.
BUSY_TIMEOUT, 4, cycles to wait for tx_busy_i to rise after an issue before treating the byte as sent.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
wr_e_i  input  1  write strobe; one byte is pushed per cycle where it is high
wr_d_i  input  8  write data
full_o  output  1  count_o == DEPTH
empty_o  output  1  count_o == 0
count_o  output  log2(DEPTH)+1  bytes currently stored
overflow_o  output  1  sticky flag: a write was dropped
tx_busy_i  input  1  uart_tx busy_o
tx_e_o  output  1  to uart_tx e_i; single-cycle pulse
tx_d_o  output  8  to uart_tx d_i; registered, valid while tx_e_o is high

Behaviour:
- Reset (synchronous, active-high):
  - tx_e_o=0, tx_d_o=0, count_o=0, empty_o=1, full_o=0, overflow_o=0.
  - Read and write pointers cleared; FSM to IDLE.
  - Mid-operation: stored bytes are discarded. A pulse on tx_e_o in the reset cycle is dropped (0 on the next cycle).
- Storage: circular buffer of DEPTH bytes.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count_o is a separate counter.
- Write (cycle where wr_e_i=1):
  - Accepted if count_o<DEPTH, or if a pop occurs the same cycle.
  - Otherwise the byte is dropped and overflow_o is set; it stays 1 until reset.
- Pop: occurs on the clock edge that moves the FSM from IDLE to ISSUE.
  - The head byte is registered into tx_d_o and the read pointer advances.
- Count update:
  - Simultaneous accepted write and pop: count unchanged.
  - Write only: +1. Pop only: −1.
- FSM states:
  - IDLE: if count_o!=0 and tx_busy_i=0 -> ISSUE (pop). Otherwise stay.
  - ISSUE: tx_e_o=1 for exactly this one cycle -> WAIT_BUSY; timeout counter loads 0.
  - WAIT_BUSY: if tx_busy_i=1 -> WAIT_DONE. Otherwise increment the counter; when it reaches BUSY_TIMEOUT-1 -> IDLE (byte considered sent, no retry).
  - WAIT_DONE: if tx_busy_i=0 -> IDLE. Otherwise stay.
- tx_e_o is high only in ISSUE, so it is never high on two consecutive cycles.
- tx_d_o holds its value outside ISSUE.
- Latency, empty FIFO, FSM in IDLE, tx_busy_i=0:
  - wr_e_i sampled at edge N.
  - count_o=1 after edge N.
  - FSM enters ISSUE at edge N+1, so tx_e_o is high in the cycle following edge N+1 (2 cycles after the write).
- Minimum byte-to-byte spacing on tx_e_o: ISSUE + WAIT_BUSY + WAIT_DONE + IDLE, i.e. 4 cycles plus the busy duration.
- full_o, empty_o and count_o are registered and consistent with each other every cycle.
- Reads of an empty FIFO cannot occur: IDLE gates the pop on count_o!=0.

Test Plan:
- Single byte: reset, write 0xA5, model uart_tx asserting busy 1 cycle after e_i for 20 cycles.
  - Required: tx_e_o high exactly once, 2 cycles after the write, with tx_d_o=0xA5.
  - Required: count_o goes 1->0 on the issue edge.
- Burst: write 0x01..0x05 on consecutive cycles while the busy model is active.
  - Required: five tx_e_o pulses carrying 0x01..0x05 in order.
  - Required: each pulse occurs only after tx_busy_i has fallen; no pulse while tx_busy_i=1.
- Full/overflow: hold tx_busy_i=1, write DEPTH+1 bytes (0x10..0x20).
  - Required: full_o=1 after 16 writes, the 17th byte (0x20) is dropped, overflow_o=1.
  - Required: after release, 16 bytes 0x10..0x1F are transmitted.
  - Required: overflow_o stays 1 until reset.
- Wrap-around and simultaneous events:
  - Push/pop 40 bytes with random write gaps; all bytes are delivered in order across pointer wrap.
  - With full_o=1, a write coinciding with a pop is accepted and count stays 16.
- Busy timeout: tx_busy_i tied 0, write 0x3C.
  - Required: tx_e_o pulse, then after BUSY_TIMEOUT cycles the FSM returns to IDLE.
  - Required: a second byte 0x3D is issued next; no hang.
- Reset mid-operation: with 3 bytes queued and the FSM in WAIT_DONE, assert reset for 1 cycle.
  - Required: count_o=0, empty_o=1, tx_e_o=0, overflow_o=0 next cycle.
  - Required: no further tx_e_o until a new write.
